// File: rtl/ka58_seq_pkg.sv
// Shared types and helpers for the sequential 58x58 carry-less Karatsuba multiplier.
// Combinational only; no handshake or backpressure of its own.
package ka_pkg;
    localparam int N  = 58;
    localparam int H  = 29;
    localparam int PW = 2 * H - 1;
    localparam int OW = 2 * N - 1;

    typedef enum logic [2:0] {IDLE, HI, LO, MID, DONE} ka_state_t;

    typedef struct packed {
        logic [N-1:0] a;
        logic [N-1:0] b;
    } opnd_t;

    // Middle term of the Karatsuba fold lands at x^H; T0^T1 removes the high/low cross terms.
    function automatic logic [OW-1:0] ka_combine(input logic [PW-1:0] t0,
                                                 input logic [PW-1:0] t1,
                                                 input logic [PW-1:0] t2);
        return {t1, {N{1'b0}}} ^ {{H{1'b0}}, t0 ^ t1 ^ t2, {H{1'b0}}} ^ {{N{1'b0}}, t0};
    endfunction

    function automatic logic [28:0] clmul15(input logic [14:0] x, input logic [14:0] y);
        logic [28:0] r;
        r = '0;
        for (int i = 0; i < 15; i++) begin
            if (y[i]) r = r ^ ({14'b0, x} << i);
        end
        return r;
    endfunction
endpackage

// File: rtl/ka58_seq_if.sv
// Operand/result stream bundle; master is the producer+consumer side, slave is the multiplier.
// Plain wires, zero latency; backpressure is carried by in_ready/out_ready.
interface ka58_seq_if;
    import ka_pkg::*;

    logic          in_valid;
    logic          in_ready;
    logic [N-1:0]  in_a;
    logic [N-1:0]  in_b;
    logic          out_valid;
    logic          out_ready;
    logic [OW-1:0] out_p;
    logic          busy;

    modport master (
        output in_valid, in_a, in_b, out_ready,
        input  in_ready, out_valid, out_p, busy
    );

    modport slave (
        input  in_valid, in_a, in_b, out_ready,
        output in_ready, out_valid, out_p, busy
    );
endinterface

// File: rtl/ka58_seq_ka29.sv
// 29x29 carry-less multiply core, one Karatsuba level over 15/14-bit halves.
// Purely combinational (0 cycles); no handshake, no backpressure.
module KA29
    import ka_pkg::*;
(
    input  logic [28:0] a,
    input  logic [28:0] b,
    output logic [56:0] p
);
    logic [14:0] al, ah, bl, bh;
    logic [28:0] ll, hh, mm, mid;

    assign al = a[14:0];
    assign ah = {1'b0, a[28:15]};
    assign bl = b[14:0];
    assign bh = {1'b0, b[28:15]};

    assign ll  = clmul15(al, bl);
    assign hh  = clmul15(ah, bh);
    assign mm  = clmul15(al ^ ah, bl ^ bh);
    assign mid = mm ^ ll ^ hh;

    assign p = ({28'b0, hh} << 30) ^ ({28'b0, mid} << 15) ^ {28'b0, ll};
endmodule

// File: rtl/ka58_seq.sv
// 58x58 GF(2) multiplier sharing one KA29 core over HI/LO/MID; 3 cycles accept->out_valid, II 4.
// Holds result, T registers and state while out_valid && !out_ready; in_ready sees out_ready combinationally.
module ka58_seq #(
    parameter int N = 58,
    parameter int H = 29
) (
    input  logic       clk,
    input  logic       rst_n,
    ka58_seq_if.slave  bus
);
    import ka_pkg::*;

    if (N != 58 || H != N / 2) begin : g_width_check
        $error("ka58_seq supports only N=58, H=29");
    end

    ka_state_t     state;
    opnd_t         opnd;
    logic [PW-1:0] t0;
    logic [PW-1:0] t1;
    logic [PW-1:0] core_p;
    logic [H-1:0]  core_a;
    logic [H-1:0]  core_b;
    logic [OW-1:0] out_p;
    logic          out_valid;
    logic          busy;
    logic          in_ready;
    logic          accept;

    // Idle states drive zero into the core to keep it quiet.
    always_comb begin
        core_a = '0;
        core_b = '0;
        case (state)
            HI: begin
                core_a = opnd.a[N-1:H];
                core_b = opnd.b[N-1:H];
            end
            LO: begin
                core_a = opnd.a[H-1:0];
                core_b = opnd.b[H-1:0];
            end
            MID: begin
                core_a = opnd.a[N-1:H] ^ opnd.a[H-1:0];
                core_b = opnd.b[N-1:H] ^ opnd.b[H-1:0];
            end
            default: ;
        endcase
    end

    KA29 u_core (
        .a (core_a),
        .b (core_b),
        .p (core_p)
    );

    assign in_ready = (state == IDLE) || (state == DONE && bus.out_ready);
    assign accept   = bus.in_valid && in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            opnd      <= '0;
            t0        <= '0;
            t1        <= '0;
            out_p     <= '0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        opnd  <= '{a: bus.in_a, b: bus.in_b};
                        state <= HI;
                        busy  <= 1'b1;
                    end
                end
                HI: begin
                    t1    <= core_p;
                    state <= LO;
                end
                LO: begin
                    t0    <= core_p;
                    state <= MID;
                end
                MID: begin
                    out_p     <= ka_combine(t0, t1, core_p);
                    out_valid <= 1'b1;
                    state     <= DONE;
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid <= 1'b0;
                        if (accept) begin
                            opnd  <= '{a: bus.in_a, b: bus.in_b};
                            state <= HI;
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end
                end
                default: begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid;
    assign bus.out_p     = out_p;
    assign bus.busy      = busy;
endmodule

// File: tb/tb_ka58_seq.sv
// Scoreboard bench for ka58_seq: directed corner products, backpressure, mid-op reset, random stream.
module tb_ka58_seq;
    import ka_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ka58_seq_if bus();

    ka58_seq #(.N(58), .H(29)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_chk = 0;
    int n_pass = 0;
    int n_in = 0;
    int n_out = 0;
    bit drv_done = 0;
    logic [OW-1:0] exp_q[$];

    localparam logic [N-1:0] ALL1 = 58'h3FF_FFFF_FFFF_FFFF;

    // Schoolbook polynomial product: b shifted by every set bit of a, XOR-accumulated.
    function automatic logic [OW-1:0] ref_mul(input logic [N-1:0] a, input logic [N-1:0] b);
        logic [OW-1:0] r;
        r = '0;
        for (int i = 0; i < N; i++) begin
            if (a[i]) r = r ^ ({{(OW-N){1'b0}}, b} << i);
        end
        return r;
    endfunction

    task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", nm, act, exp);
    endtask

    task automatic send(input logic [N-1:0] a, input logic [N-1:0] b,
                        input logic [OW-1:0] exp, output int waits);
        bit ok;
        ok = 0;
        waits = 0;
        bus.in_valid = 1'b1;
        bus.in_a = a;
        bus.in_b = b;
        while (!ok && waits < 300) begin
            @(negedge clk);
            if (bus.in_ready) ok = 1;
            else waits++;
        end
        if (ok) begin
            exp_q.push_back(exp);
            n_in++;
        end else begin
            n_chk++;
            $display("FAIL accept_timeout: in_ready low for %0d cycles, expected 1", waits);
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_valid(output int cyc);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!bus.out_valid && cyc < 50);
        if (!bus.out_valid) begin
            n_chk++;
            $display("FAIL valid_timeout: out_valid low after %0d cycles, expected 1", cyc);
        end
    endtask

    task automatic drain();
        int c;
        c = 0;
        while (exp_q.size() != 0 && c < 200) begin
            @(negedge clk);
            c++;
        end
        if (exp_q.size() != 0) begin
            n_chk++;
            $display("FAIL drain_timeout: %0d results outstanding, expected 0", exp_q.size());
        end
        @(posedge clk);
        #1;
    endtask

    // Monitor: every accepted product is popped and compared in order.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && bus.out_valid && bus.out_ready) begin
                n_out++;
                if (exp_q.size() == 0) begin
                    n_chk++;
                    $display("FAIL unexpected_out: got product %h, expected no result", bus.out_p);
                end else begin
                    check("product", {13'b0, bus.out_p}, {13'b0, exp_q.pop_front()});
                end
            end
        end
    end

    initial begin
        int w;
        int cyc;
        int ir_hi;
        bit stable;
        logic [OW-1:0] snap;
        logic [N-1:0] a, b, top_n;
        logic [OW-1:0] top_p, ones_p;

        bus.in_valid  = 1'b0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("rst_in_ready", {127'b0, bus.in_ready}, 128'd1);
        check("rst_out_valid", {127'b0, bus.out_valid}, 128'd0);
        check("rst_busy", {127'b0, bus.busy}, 128'd0);
        check("rst_out_p", {13'b0, bus.out_p}, 128'd0);
        @(posedge clk);
        #1 bus.out_ready = 1'b1;

        // 1*1 with latency and in_ready profile over HI/LO/MID
        send(58'd1, 58'd1, 115'd1, w);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("busy_in_ready", {127'b0, bus.in_ready}, 128'd0);
            check("early_out_valid", {127'b0, bus.out_valid}, 128'd0);
        end
        @(negedge clk);
        check("latency3_out_valid", {127'b0, bus.out_valid}, 128'd1);
        drain();

        top_n = '0;
        top_n[N-1] = 1'b1;
        top_p = '0;
        top_p[OW-1] = 1'b1;
        ones_p = {57'b0, ALL1};
        send(58'd3, 58'd3, 115'd5, w);
        send(top_n, top_n, top_p, w);
        send(ALL1, 58'd1, ones_p, w);
        send(ALL1, ALL1, ref_mul(ALL1, ALL1), w);
        drain();

        // Backpressure: result held, no acceptance, then same-cycle handoff
        bus.out_ready = 1'b0;
        a = 58'h123_4567_89AB_CDEF;
        b = 58'h2FE_DCBA_9876_5432;
        send(a, b, ref_mul(a, b), w);
        wait_valid(cyc);
        snap = bus.out_p;
        stable = 1;
        ir_hi = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (bus.out_p !== snap || bus.out_valid !== 1'b1) stable = 0;
            if (bus.in_ready) ir_hi++;
        end
        check("bp_hold", {127'b0, stable}, 128'd1);
        check("bp_in_ready_cycles", 128'(ir_hi), 128'd0);
        @(posedge clk);
        #1 bus.out_ready = 1'b1;
        send(b, a, ref_mul(b, a), w);
        check("bp_accept_wait", 128'(w), 128'd0);
        wait_valid(cyc);
        check("bp_next_latency", 128'(cyc - 1), 128'd3);
        drain();

        // Reset while in LO discards the operation
        send(58'd9, 58'd6, ref_mul(58'd9, 58'd6), w);
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        void'(exp_q.pop_back());
        n_in--;
        check("mid_rst_out_valid", {127'b0, bus.out_valid}, 128'd0);
        check("mid_rst_busy", {127'b0, bus.busy}, 128'd0);
        check("mid_rst_in_ready", {127'b0, bus.in_ready}, 128'd1);
        check("mid_rst_out_p", {13'b0, bus.out_p}, 128'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        send(58'd5, 58'd7, 115'd27, w);
        drain();

        // Random stream with random consumer stalls
        fork
            begin
                for (int i = 0; i < 1000; i++) begin
                    a = N'({$urandom(), $urandom()});
                    b = N'({$urandom(), $urandom()});
                    if (i % 97 == 0) a = ALL1;
                    if (i % 89 == 0) b = top_n;
                    send(a, b, ref_mul(a, b), w);
                    if ($urandom_range(0, 3) == 0) begin
                        repeat ($urandom_range(1, 3)) @(posedge clk);
                        #1;
                    end
                end
                drv_done = 1;
            end
            begin
                while (!drv_done) begin
                    @(posedge clk);
                    #1 bus.out_ready = ($urandom_range(0, 3) != 0);
                end
                bus.out_ready = 1'b1;
            end
        join
        bus.out_ready = 1'b1;
        drain();

        check("in_out_count", 128'(n_out), 128'(n_in));
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
